// File: rtl/fm_wb_arbiter.sv
// Purpose : round-robin write-back arbiter from NUM_ROW PE-row guard generators onto
//           one fm buffer write port and one guard buffer write port, with frame beat counting.
// Latency : 1 cycle from grant (valid & ready) to write request on the registered port.
// Backpressure: a port's output register holds while en=1 and its ready is low; no grant
//           is issued to that port until the slot frees, so rows stall on their valid.
//
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   start_i / expected_i / base_addr_i   frame start, total data beats, per-row fm base
//   wb_valid_i / wb_data_i / wb_ready_o  per-row fm data handshake (ready one-hot)
//   guard_valid_i / guard_i / guard_ready_o  per-row guard handshake (ready one-hot)
//   fm_wr_en_o / fm_wr_addr_o / fm_wr_data_o / fm_wr_ready_i   registered fm write port
//   gd_wr_en_o / gd_wr_addr_o / gd_wr_data_o / gd_wr_ready_i   registered guard write port
//   busy_o, done_o             frame in progress, single-cycle frame-drained pulse
module fm_wb_arbiter #(
    parameter int NUM_ROW = 8,
    parameter int DATA_W  = 8,
    parameter int GUARD_W = 6,
    parameter int ADDR_W  = 12,
    parameter int GCNT_W  = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start_i,
    input  logic [15:0]                         expected_i,
    input  logic [NUM_ROW*ADDR_W-1:0]           base_addr_i,
    input  logic [NUM_ROW-1:0]                  wb_valid_i,
    input  logic [NUM_ROW*DATA_W-1:0]           wb_data_i,
    output logic [NUM_ROW-1:0]                  wb_ready_o,
    input  logic [NUM_ROW-1:0]                  guard_valid_i,
    input  logic [NUM_ROW*GUARD_W-1:0]          guard_i,
    output logic [NUM_ROW-1:0]                  guard_ready_o,
    output logic                                fm_wr_en_o,
    output logic [ADDR_W-1:0]                   fm_wr_addr_o,
    output logic [DATA_W-1:0]                   fm_wr_data_o,
    input  logic                                fm_wr_ready_i,
    output logic                                gd_wr_en_o,
    output logic [$clog2(NUM_ROW)+GCNT_W-1:0]   gd_wr_addr_o,
    output logic [GUARD_W-1:0]                  gd_wr_data_o,
    input  logic                                gd_wr_ready_i,
    output logic                                busy_o,
    output logic                                done_o
);

    localparam int IDX_W = $clog2(NUM_ROW);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Returns {hit, index}: first asserted request at or after ptr, searching upward
    // with wrap. The loop runs from the farthest distance down so the nearest hit wins.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_ROW-1:0] req,
                                               input logic [IDX_W-1:0]   ptr);
        logic [IDX_W:0] res;
        int             idx;
        res = '0;
        for (int k = NUM_ROW - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_ROW) idx = idx - NUM_ROW;
            if (req[IDX_W'(idx)]) res = {1'b1, IDX_W'(idx)};
        end
        return res;
    endfunction

    function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] sel);
        logic [IDX_W-1:0] nxt;
        if (sel == IDX_W'(NUM_ROW - 1)) nxt = '0;
        else                            nxt = sel + 1'b1;
        return nxt;
    endfunction

    // ---------------------------------------------------------------- state
    state_t              r_state;
    state_t              w_state_nxt;
    logic [15:0]         r_expected;
    logic [15:0]         r_beats;
    logic [ADDR_W-1:0]   r_base [NUM_ROW];
    logic [ADDR_W-1:0]   r_fcnt [NUM_ROW];
    logic [GCNT_W-1:0]   r_gcnt [NUM_ROW];
    logic [IDX_W-1:0]    r_rr_d;
    logic [IDX_W-1:0]    r_rr_g;

    logic                r_fm_wr_en;
    logic [ADDR_W-1:0]   r_fm_wr_addr;
    logic [DATA_W-1:0]   r_fm_wr_data;
    logic                r_gd_wr_en;
    logic [IDX_W+GCNT_W-1:0] r_gd_wr_addr;
    logic [GUARD_W-1:0]  r_gd_wr_data;

    // ---------------------------------------------------------------- unpack rows
    logic [DATA_W-1:0]   w_data  [NUM_ROW];
    logic [GUARD_W-1:0]  w_guard [NUM_ROW];
    logic [ADDR_W-1:0]   w_base  [NUM_ROW];

    always_comb begin
        for (int r = 0; r < NUM_ROW; r++) begin
            w_data[r]  = wb_data_i[r*DATA_W +: DATA_W];
            w_guard[r] = guard_i[r*GUARD_W +: GUARD_W];
            w_base[r]  = base_addr_i[r*ADDR_W +: ADDR_W];
        end
    end

    // ---------------------------------------------------------------- arbitration
    logic [IDX_W:0]      w_d_pick;
    logic [IDX_W:0]      w_g_pick;
    logic                w_d_hit;
    logic                w_g_hit;
    logic [IDX_W-1:0]    w_d_sel;
    logic [IDX_W-1:0]    w_g_sel;
    logic                w_d_allow;
    logic                w_g_allow;
    logic                w_d_fire;
    logic                w_g_fire;
    logic                w_start;
    logic [15:0]         w_beats_nxt;

    assign w_d_pick = rr_pick(wb_valid_i, r_rr_d);
    assign w_g_pick = rr_pick(guard_valid_i, r_rr_g);
    assign w_d_hit  = w_d_pick[IDX_W];
    assign w_g_hit  = w_g_pick[IDX_W];
    assign w_d_sel  = w_d_pick[IDX_W-1:0];
    assign w_g_sel  = w_g_pick[IDX_W-1:0];

    // Data grants stop at the frame's beat total so the counter can never overshoot.
    assign w_d_allow = (r_state == ST_RUN) && (r_beats != r_expected)
                     && (!r_fm_wr_en || fm_wr_ready_i);
    assign w_g_allow = ((r_state == ST_RUN) || (r_state == ST_DRAIN))
                     && (!r_gd_wr_en || gd_wr_ready_i);

    assign w_d_fire = w_d_allow && w_d_hit;
    assign w_g_fire = w_g_allow && w_g_hit;
    assign w_start  = (r_state == ST_IDLE) && start_i;

    assign w_beats_nxt = r_beats + {15'd0, w_d_fire};

    assign wb_ready_o    = w_d_fire ? (NUM_ROW'(1) << w_d_sel) : '0;
    assign guard_ready_o = w_g_fire ? (NUM_ROW'(1) << w_g_sel) : '0;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start_i) w_state_nxt = (expected_i == 16'd0) ? ST_DRAIN : ST_RUN;
            end
            ST_RUN: begin
                if (w_beats_nxt == r_expected) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Both ports empty and no guard word left upstream: frame is drained.
                if (!r_fm_wr_en && !r_gd_wr_en && (guard_valid_i == '0))
                    w_state_nxt = ST_DONE;
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    assign busy_o = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign done_o = (r_state == ST_DONE);

    // ---------------------------------------------------------------- counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_expected <= '0;
            r_beats    <= '0;
            for (int r = 0; r < NUM_ROW; r++) begin
                r_base[r] <= '0;
                r_fcnt[r] <= '0;
                r_gcnt[r] <= '0;
            end
        end else if (w_start) begin
            r_expected <= expected_i;
            r_beats    <= '0;
            for (int r = 0; r < NUM_ROW; r++) begin
                r_base[r] <= w_base[r];
                r_fcnt[r] <= '0;
                r_gcnt[r] <= '0;
            end
        end else begin
            if (w_d_fire) begin
                r_fcnt[w_d_sel] <= r_fcnt[w_d_sel] + 1'b1;
                r_beats         <= w_beats_nxt;
            end
            if (w_g_fire) r_gcnt[w_g_sel] <= r_gcnt[w_g_sel] + 1'b1;
        end
    end

    // ---------------------------------------------------------------- fm write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fm_wr_en   <= 1'b0;
            r_fm_wr_addr <= '0;
            r_fm_wr_data <= '0;
            r_rr_d       <= '0;
        end else if (w_d_fire) begin
            r_fm_wr_en   <= 1'b1;
            r_fm_wr_addr <= r_base[w_d_sel] + r_fcnt[w_d_sel];
            r_fm_wr_data <= w_data[w_d_sel];
            r_rr_d       <= rr_next(w_d_sel);
        end else if (fm_wr_ready_i) begin
            r_fm_wr_en   <= 1'b0;
        end
    end

    // ---------------------------------------------------------------- guard write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gd_wr_en   <= 1'b0;
            r_gd_wr_addr <= '0;
            r_gd_wr_data <= '0;
            r_rr_g       <= '0;
        end else if (w_g_fire) begin
            r_gd_wr_en   <= 1'b1;
            r_gd_wr_addr <= {w_g_sel, r_gcnt[w_g_sel]};
            r_gd_wr_data <= w_guard[w_g_sel];
            r_rr_g       <= rr_next(w_g_sel);
        end else if (gd_wr_ready_i) begin
            r_gd_wr_en   <= 1'b0;
        end
    end

    assign fm_wr_en_o   = r_fm_wr_en;
    assign fm_wr_addr_o = r_fm_wr_addr;
    assign fm_wr_data_o = r_fm_wr_data;
    assign gd_wr_en_o   = r_gd_wr_en;
    assign gd_wr_addr_o = r_gd_wr_addr;
    assign gd_wr_data_o = r_gd_wr_data;

endmodule
